// File: rtl/gray_pos_decoder_pkg.sv
// Shared definitions for Gray-code receive blocks: FSM state encodings,
// error-counter width/saturation and the synchronizer fill count.
package gray_pos_decoder_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_PRIME = 2'd1,
    ST_TRACK = 2'd2
  } gray_state_e;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  // Down-counter reload: terminal count reached after two edges in SYNC.
  localparam logic [1:0] SYNC_RELOAD = 2'd1;

  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gray_pos_decoder_gray2bin.sv
// Pure combinational Gray-to-binary conversion of a NUM_PIN+1 bit bus.
module gray2bin #(
  parameter int NUM_PIN = 3
) (
  input  logic [NUM_PIN:0] gray,
  output logic [NUM_PIN:0] bin
);

  function automatic logic [NUM_PIN:0] g2b(input logic [NUM_PIN:0] g);
    logic [NUM_PIN:0] b;
    b          = '0;
    b[NUM_PIN] = g[NUM_PIN];
    for (int i = NUM_PIN - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    bin = g2b(gray);
  end

endmodule

// File: rtl/gray_pos_decoder.sv
// Synchronizes an asynchronous Gray bus, decodes it and tracks a signed
// position from legal +/-1 code steps; illegal jumps are flagged and counted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SYNC  | after reset, let the two synchronizer flops fill
// ST_PRIME | take the first decoded value as baseline, no step reported
// ST_TRACK | compare each decoded value against the baseline
module gray_pos_decoder
  import gray_pos_decoder_pkg::*;
#(
  parameter int NUM_PIN = 3,
  parameter int POS_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_PIN:0]     GRAY_IN,
  input  logic                 CLR,
  input  logic                 ERR_CLR,
  output logic [NUM_PIN:0]     BIN_OUT,
  output logic [POS_W-1:0]     POS,
  output logic                 STEP,
  output logic                 DIR,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic                 READY
);

  localparam int W = NUM_PIN + 1;

  logic [W-1:0]         s1_q, s2_q;
  gray_state_e          state_q, state_d;
  logic [1:0]           sync_cnt_q, sync_cnt_d;
  logic [W-1:0]         bin_q, bin_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 ready_q, ready_d;

  logic [W-1:0] bin_s2;
  logic [W-1:0] delta;
  logic         in_track, is_up, is_dn, is_bad;

  gray2bin #(.NUM_PIN(NUM_PIN)) u_gray2bin (
    .gray (s2_q),
    .bin  (bin_s2)
  );

  // Modular difference makes the max->0 and 0->max wraps legal steps.
  always_comb begin
    delta    = bin_s2 - bin_q;
    in_track = (state_q == ST_TRACK);
    is_up    = in_track && (delta == W'(1));
    is_dn    = in_track && (delta == '1);
    is_bad   = in_track && (delta != '0) && !is_up && !is_dn;
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    bin_d      = bin_q;
    pos_d      = pos_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      ST_SYNC: begin
        if (sync_cnt_q == 2'd0) state_d = ST_PRIME;
        else                    sync_cnt_d = sync_cnt_q - 2'd1;
      end
      ST_PRIME: begin
        bin_d   = bin_s2;
        state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (is_up || is_dn) begin
          bin_d  = bin_s2;
          step_d = 1'b1;
          dir_d  = is_up;
          pos_d  = is_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end else if (is_bad) begin
          bin_d = bin_s2;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    ready_d = (state_d == ST_TRACK);

    if (CLR) pos_d = '0;

    // A fresh error in the same cycle as ERR_CLR still registers once.
    if (is_bad) begin
      err_d     = 1'b1;
      err_cnt_d = ERR_CLR ? ERR_CNT_W'(1) : err_cnt_inc(err_cnt_q);
    end else if (ERR_CLR) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q       <= '0;
      s2_q       <= '0;
      state_q    <= ST_SYNC;
      sync_cnt_q <= SYNC_RELOAD;
      bin_q      <= '0;
      pos_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      s1_q       <= GRAY_IN;
      s2_q       <= s1_q;
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bin_q      <= bin_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign BIN_OUT = bin_q;
  assign POS     = pos_q;
  assign STEP    = step_q;
  assign DIR     = dir_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign READY   = ready_q;

endmodule

// File: tb/tb_gray_pos_decoder.sv
// Directed-vector bench for gray_pos_decoder: stimulus pushes expected
// outputs tagged with the cycle they must appear in; a monitor pops and compares.
module tb_gray_pos_decoder;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  GRAY_IN;
  logic        CLR, ERR_CLR;
  logic [3:0]  BIN_OUT;
  logic [15:0] POS;
  logic        STEP, DIR, ERR, READY;
  logic [7:0]  ERR_CNT;

  gray_pos_decoder #(.NUM_PIN(3), .POS_W(16)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .GRAY_IN (GRAY_IN),
    .CLR     (CLR),
    .ERR_CLR (ERR_CLR),
    .BIN_OUT (BIN_OUT),
    .POS     (POS),
    .STEP    (STEP),
    .DIR     (DIR),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT),
    .READY   (READY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       tag;
    logic [3:0]  bin;
    logic [15:0] pos;
    logic        step, dir, err;
    logic [7:0]  cnt;
    logic        rdy;
  } exp_t;

  typedef struct {
    string       tag;
    logic [3:0]  g;
    logic        clr, eclr;
    logic [3:0]  bin;
    logic [15:0] pos;
    logic        step, dir, err;
    logic [7:0]  cnt;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        chk({e.tag, ".slot"}, cyc, e.at);
      end else begin
        chk({e.tag, ".bin"},   BIN_OUT, e.bin);
        chk({e.tag, ".pos"},   POS,     e.pos);
        chk({e.tag, ".step"},  STEP,    e.step);
        chk({e.tag, ".dir"},   DIR,     e.dir);
        chk({e.tag, ".err"},   ERR,     e.err);
        chk({e.tag, ".cnt"},   ERR_CNT, e.cnt);
        chk({e.tag, ".ready"}, READY,   e.rdy);
      end
    end
  end

  task automatic expect_at(int at, string tag, logic [3:0] b, logic [15:0] p,
                           logic s, logic d, logic er, logic [7:0] c, logic r);
    exp_t e;
    e.at = at; e.tag = tag; e.bin = b; e.pos = p;
    e.step = s; e.dir = d; e.err = er; e.cnt = c; e.rdy = r;
    sb.push_back(e);
  endtask

  // Called at a negedge; the response lands three edges later.
  task automatic run_vec(vec_t v);
    GRAY_IN = v.g;
    expect_at(cyc + 3, v.tag, v.bin, v.pos, v.step, v.dir, v.err, v.cnt, 1'b1);
    expect_at(cyc + 4, {v.tag, "+1"}, v.bin, v.pos, 1'b0, v.dir, v.err, v.cnt, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    CLR     = v.clr;
    ERR_CLR = v.eclr;
    @(negedge CLK);
    CLR     = 1'b0;
    ERR_CLR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".bin"},   BIN_OUT, 4'h0);
    chk({tag, ".pos"},   POS,     16'h0);
    chk({tag, ".step"},  STEP,    1'b0);
    chk({tag, ".dir"},   DIR,     1'b0);
    chk({tag, ".err"},   ERR,     1'b0);
    chk({tag, ".cnt"},   ERR_CNT, 8'h0);
    chk({tag, ".ready"}, READY,   1'b0);
  endtask

  //            tag        gray     clr  eclr  bin    pos       stp  dir  err  cnt
  vec_t main_tbl [14] = '{
    '{"hold0",   4'b0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd0},
    '{"up1",     4'b0001, 1'b0, 1'b0, 4'd1,  16'h0001, 1'b1, 1'b1, 1'b0, 8'd0},
    '{"up2",     4'b0011, 1'b0, 1'b0, 4'd2,  16'h0002, 1'b1, 1'b1, 1'b0, 8'd0},
    '{"up3",     4'b0010, 1'b0, 1'b0, 4'd3,  16'h0003, 1'b1, 1'b1, 1'b0, 8'd0},
    '{"dn2",     4'b0011, 1'b0, 1'b0, 4'd2,  16'h0002, 1'b1, 1'b0, 1'b0, 8'd0},
    '{"dn1",     4'b0001, 1'b0, 1'b0, 4'd1,  16'h0001, 1'b1, 1'b0, 1'b0, 8'd0},
    '{"dn0",     4'b0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 8'd0},
    '{"wrapdn",  4'b1000, 1'b0, 1'b0, 4'd15, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'd0},
    '{"wrapup",  4'b0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 8'd0},
    '{"jump2",   4'b0011, 1'b0, 1'b0, 4'd2,  16'h0000, 1'b0, 1'b1, 1'b1, 8'd1},
    '{"jump5",   4'b0111, 1'b0, 1'b0, 4'd5,  16'h0000, 1'b0, 1'b1, 1'b1, 8'd2},
    '{"up6",     4'b0101, 1'b0, 1'b0, 4'd6,  16'h0001, 1'b1, 1'b1, 1'b1, 8'd2},
    '{"clrstep", 4'b0100, 1'b1, 1'b0, 4'd7,  16'h0000, 1'b1, 1'b1, 1'b1, 8'd2},
    '{"errclr",  4'b0100, 1'b0, 1'b1, 4'd7,  16'h0000, 1'b0, 1'b1, 1'b0, 8'd0}
  };

  vec_t tail_tbl [3] = '{
    '{"eclrjump", 4'b0000, 1'b0, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 8'd1},
    '{"dn15",     4'b1000, 1'b0, 1'b0, 4'd15, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'd1},
    '{"up0",      4'b0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b1, 1'b1, 8'd1}
  };

  vec_t pos5_tbl [5] = '{
    '{"p1", 4'b0001, 1'b0, 1'b0, 4'd1, 16'h0001, 1'b1, 1'b1, 1'b1, 8'd255},
    '{"p2", 4'b0011, 1'b0, 1'b0, 4'd2, 16'h0002, 1'b1, 1'b1, 1'b1, 8'd255},
    '{"p3", 4'b0010, 1'b0, 1'b0, 4'd3, 16'h0003, 1'b1, 1'b1, 1'b1, 8'd255},
    '{"p4", 4'b0110, 1'b0, 1'b0, 4'd4, 16'h0004, 1'b1, 1'b1, 1'b1, 8'd255},
    '{"p5", 4'b0111, 1'b0, 1'b0, 4'd5, 16'h0005, 1'b1, 1'b1, 1'b1, 8'd255}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    RST_N   = 1'b0;
    GRAY_IN = 4'b0000;
    CLR     = 1'b0;
    ERR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");

    RST_N = 1'b1;
    k = cyc;
    expect_at(k + 1, "sync1", 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_at(k + 2, "sync2", 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_at(k + 3, "prime", 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (4) @(negedge CLK);

    foreach (main_tbl[i]) run_vec(main_tbl[i]);
    foreach (tail_tbl[i]) run_vec(tail_tbl[i]);

    // One illegal jump per cycle alternating binary 8 and 0; count starts at 1.
    for (int i = 0; i < 256; i++) begin
      GRAY_IN = (i % 2 == 0) ? 4'b1100 : 4'b0000;
      if (i == 252)
        expect_at(cyc + 3, "sat254", 4'd8, 16'h0, 1'b0, 1'b1, 1'b1, 8'd254, 1'b1);
      if (i == 255) begin
        expect_at(cyc + 3, "sat255", 4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
        expect_at(cyc + 4, "sathold", 4'd0, 16'h0, 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);
      end
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);

    foreach (pos5_tbl[i]) run_vec(pos5_tbl[i]);

    #2 RST_N = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge CLK);
    RST_N = 1'b1;
    k = cyc;
    expect_at(k + 1, "rsync1", 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_at(k + 2, "rsync2", 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_at(k + 3, "rprime", 4'd5, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    expect_at(k + 4, "rtrack", 4'd5, 16'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    repeat (6) @(negedge CLK);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
